// File: rtl/alu_io_pkg.sv
// Shared ALU front-panel definitions: entry-state encodings, byte-lane selects
// and a lane write helper, shared with the LED display mux.
package alu_io_pkg;

    localparam int OP_W = 3;

    typedef enum logic [1:0] {
        S_A    = 2'b00,
        S_B    = 2'b01,
        S_OP   = 2'b10,
        S_DONE = 2'b11
    } entry_state_t;

    localparam logic [2:0] LANE0 = 3'b000;
    localparam logic [2:0] LANE1 = 3'b001;
    localparam logic [2:0] LANE2 = 3'b010;
    localparam logic [2:0] LANE3 = 3'b011;

    // Replace one byte lane of a word; any select outside LANE0..LANE3 leaves it intact.
    function automatic logic [31:0] put_byte(logic [31:0] w, logic [2:0] sel, logic [7:0] b);
        logic [31:0] r;
        r = w;
        case (sel)
            LANE0:   r[7:0]   = b;
            LANE1:   r[15:8]  = b;
            LANE2:   r[23:16] = b;
            LANE3:   r[31:24] = b;
            default: r = w;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/operand_entry_btn_pulse.sv
// Pushbutton conditioner: 2-flop synchronizer, optional debounce
// (OPERAND_ENTRY_DEBOUNCE_EN) and rising-edge detect giving a 1-cycle pulse.
module btn_pulse #(
    parameter int DB_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic pulse
);

    logic       s1, s2, lvl, lvl_q, armed;
    logic [1:0] prime;

    if (DB_CYCLES < 2) begin : g_db_check
        $error("btn_pulse: DB_CYCLES must be >= 2");
    end

    // armed stays low until a released level is seen once the synchronizer has
    // refilled, so a button held through reset cannot fire.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            lvl_q <= 1'b0;
            prime <= 2'b00;
            armed <= 1'b0;
        end else begin
            s1    <= raw;
            s2    <= s1;
            lvl_q <= lvl;
            prime <= {prime[0], 1'b1};
            if (prime[1] && !s2)
                armed <= 1'b1;
        end
    end

`ifdef OPERAND_ENTRY_DEBOUNCE_EN
    localparam int CW = $clog2(DB_CYCLES);

    logic [CW-1:0] cnt;
    logic          db;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            db  <= 1'b0;
        end else if (s2 == db) begin
            cnt <= '0;
        end else if (cnt == CW'(DB_CYCLES - 1)) begin
            db  <= s2;
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign lvl = db;
`else
    assign lvl = s2;
`endif

    assign pulse = armed & lvl & ~lvl_q;

endmodule

// File: rtl/operand_entry.sv
// Front-panel operand entry: builds A and B byte-wise from switches, captures the
// ALU opcode, sequences A->B->OP->DONE. Debounce enabled by OPERAND_ENTRY_DEBOUNCE_EN.
module operand_entry
    import alu_io_pkg::*;
#(
    parameter int DB_CYCLES = 1000000,
    parameter int OP_W      = alu_io_pkg::OP_W
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [7:0]      SW,
    input  logic [2:0]      BYTE_SEL,
    input  logic            BTN_LOAD,
    input  logic            BTN_NEXT,
    output logic [31:0]     A,
    output logic [31:0]     B,
    output logic [OP_W-1:0] ALU_OP,
    output logic [1:0]      entry_state,
    output logic            operands_valid
);

    logic         load_p, next_p;
    entry_state_t state, state_nx;

    btn_pulse #(.DB_CYCLES(DB_CYCLES)) u_load (
        .clk(clk), .rst(rst), .raw(BTN_LOAD), .pulse(load_p)
    );

    btn_pulse #(.DB_CYCLES(DB_CYCLES)) u_next (
        .clk(clk), .rst(rst), .raw(BTN_NEXT), .pulse(next_p)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= S_A;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (next_p) begin
            case (state)
                S_A:     state_nx = S_B;
                S_B:     state_nx = S_OP;
                S_OP:    state_nx = S_DONE;
                default: state_nx = S_A;
            endcase
        end
    end

    // Loads target the pre-advance state, so a simultaneous next still writes here.
    always_ff @(posedge clk) begin
        if (rst) begin
            A              <= '0;
            B              <= '0;
            ALU_OP         <= '0;
            operands_valid <= 1'b0;
        end else begin
            if (load_p) begin
                case (state)
                    S_A:     A      <= put_byte(A, BYTE_SEL, SW);
                    S_B:     B      <= put_byte(B, BYTE_SEL, SW);
                    S_OP:    ALU_OP <= SW[OP_W-1:0];
                    default: ;
                endcase
            end
            operands_valid <= (state_nx == S_DONE);
        end
    end

    assign entry_state = state;

endmodule

// File: tb/tb_operand_entry.sv
// Scoreboard bench for operand_entry: directed panel sequences push expected
// register snapshots; a negedge monitor pops and compares them.
module tb_operand_entry;

    localparam int DBC = 8;

    typedef struct {
        string       name;
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  op;
        logic [1:0]  st;
        logic        v;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  SW;
    logic [2:0]  BYTE_SEL;
    logic        BTN_LOAD, BTN_NEXT;
    logic [31:0] A, B;
    logic [2:0]  ALU_OP;
    logic [1:0]  entry_state;
    logic        operands_valid;

    int   errors = 0;
    int   checks = 0;
    exp_t exp_q[$];

    operand_entry #(.DB_CYCLES(DBC), .OP_W(3)) dut (
        .clk(clk), .rst(rst), .SW(SW), .BYTE_SEL(BYTE_SEL),
        .BTN_LOAD(BTN_LOAD), .BTN_NEXT(BTN_NEXT),
        .A(A), .B(B), .ALU_OP(ALU_OP),
        .entry_state(entry_state), .operands_valid(operands_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk({e.name, ".A"},     A,                      e.a);
            chk({e.name, ".B"},     B,                      e.b);
            chk({e.name, ".op"},    {29'd0, ALU_OP},        {29'd0, e.op});
            chk({e.name, ".state"}, {30'd0, entry_state},   {30'd0, e.st});
            chk({e.name, ".valid"}, {31'd0, operands_valid}, {31'd0, e.v});
        end
    end

    task automatic expect_now(input string n, input logic [31:0] a, input logic [31:0] b,
                              input logic [2:0] op, input logic [1:0] st, input logic v);
        exp_t e;
        e.name = n; e.a = a; e.b = b; e.op = op; e.st = st; e.v = v;
        exp_q.push_back(e);
        @(posedge clk); #1;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press(input logic ld, input logic nx);
        BTN_LOAD = ld; BTN_NEXT = nx;
        cycles(4);
        BTN_LOAD = 1'b0; BTN_NEXT = 1'b0;
        cycles(5);
    endtask

    task automatic load(input logic [7:0] sw, input logic [2:0] sel);
        SW = sw; BYTE_SEL = sel;
        press(1'b1, 1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycles(2);
        rst = 1'b0;
        cycles(4);
    endtask

    initial begin
        rst = 1'b1; SW = '0; BYTE_SEL = '0; BTN_LOAD = 1'b0; BTN_NEXT = 1'b0;
        cycles(1);
        do_reset();
        expect_now("reset", 32'h0, 32'h0, 3'd0, 2'b00, 1'b0);

`ifndef OPERAND_ENTRY_DEBOUNCE_EN
        load(8'h78, 3'd0);
        expect_now("a_byte0", 32'h0000_0078, 32'h0, 3'd0, 2'b00, 1'b0);
        load(8'h56, 3'd1);
        load(8'h34, 3'd2);
        load(8'h12, 3'd3);
        expect_now("a_full", 32'h1234_5678, 32'h0, 3'd0, 2'b00, 1'b0);

        press(1'b0, 1'b1);
        expect_now("to_b", 32'h1234_5678, 32'h0, 3'd0, 2'b01, 1'b0);
        load(8'hFF, 3'd1);
        load(8'hAA, 3'd5);
        expect_now("b_lane", 32'h1234_5678, 32'h0000_FF00, 3'd0, 2'b01, 1'b0);

        press(1'b0, 1'b1);
        load(8'b1111_0101, 3'd6);
        expect_now("opcode", 32'h1234_5678, 32'h0000_FF00, 3'b101, 2'b10, 1'b0);
        press(1'b0, 1'b1);
        expect_now("done", 32'h1234_5678, 32'h0000_FF00, 3'b101, 2'b11, 1'b1);
        load(8'h33, 3'd0);
        expect_now("done_ld", 32'h1234_5678, 32'h0000_FF00, 3'b101, 2'b11, 1'b1);

        press(1'b0, 1'b1);
        expect_now("wrap", 32'h1234_5678, 32'h0000_FF00, 3'b101, 2'b00, 1'b0);
        SW = 8'h11; BYTE_SEL = 3'd0;
        press(1'b1, 1'b1);
        expect_now("ld_nx", 32'h1234_5611, 32'h0000_FF00, 3'b101, 2'b01, 1'b0);

        // Hold LOAD in S_OP through reset; the held level must not write after reset.
        press(1'b0, 1'b1);
        SW = 8'h5A; BYTE_SEL = 3'd0;
        BTN_LOAD = 1'b1;
        cycles(5);
        expect_now("op_hold", 32'h1234_5611, 32'h0000_FF00, 3'b010, 2'b10, 1'b0);
        rst = 1'b1;
        cycles(2);
        rst = 1'b0;
        cycles(10);
        expect_now("rst_hold", 32'h0, 32'h0, 3'd0, 2'b00, 1'b0);
        BTN_LOAD = 1'b0;
        cycles(5);
        expect_now("released", 32'h0, 32'h0, 3'd0, 2'b00, 1'b0);
        load(8'h5A, 3'd0);
        expect_now("repress", 32'h0000_005A, 32'h0, 3'd0, 2'b00, 1'b0);
`else
        begin
            int lat;
            SW = 8'h3C; BYTE_SEL = 3'd0;
            BTN_LOAD = 1'b1; cycles(1);
            BTN_LOAD = 1'b0; cycles(1);
            BTN_LOAD = 1'b1; cycles(2);
            BTN_LOAD = 1'b0; cycles(1);
            BTN_LOAD = 1'b1;
            lat = 0;
            while (A !== 32'h3C && lat < 30) begin
                cycles(1);
                lat++;
            end
            checks++;
            if (lat < 10 || lat > 11) begin
                errors++;
                $display("FAIL db_latency: got %0d cycles expected 10..11", lat);
            end
            SW = 8'hC3;
            cycles(20 - lat);
            expect_now("db_one_write", 32'h0000_003C, 32'h0, 3'd0, 2'b00, 1'b0);
            BTN_LOAD = 1'b0;
            cycles(20);
            expect_now("db_release", 32'h0000_003C, 32'h0, 3'd0, 2'b00, 1'b0);
        end
`endif

        cycles(3);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/operand_entry.md
Name: operand_entry

Overview:
- Front-panel input block feeding the ALU: the write-side counterpart of the result/flag LED display mux.
- Builds 32-bit operands A and B one byte at a time from 8 slide switches, using the same byte-lane select encoding as the display (000=[7:0], 001=[15:8], 010=[23:16], 011=[31:24]).
- Captures a 3-bit ALU opcode.
- Sequences entry A → B → OP → DONE with pushbuttons, and raises `operands_valid` when the ALU inputs are complete.

Parameters:
- `DB_CYCLES`, 1000000, debounce stability window in clk cycles (10 ms at 100 MHz); must be ≥2.
- `OP_W`, 3, ALU opcode width.

Ports:
- `clk` input 1: system clock; all state changes on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `SW` input 8: data byte from slide switches.
- `BYTE_SEL` input 3: byte-lane select; same encoding as the LED display switch.
- `BTN_LOAD` input 1: raw pushbuttonHere; asynchronous and bouncy. Writes `SW` into the current target.
- `BTN_NEXT` input 1: raw pushbutton; asynchronous and bouncy. Advances the entry state.
- `A` output 32: operand A register.
- `B` output 32: operand B register.
- `ALU_OP` output `OP_W`: opcode register.
- `entry_state` output 2: current state (00=S_A, 01=S_B, 10=S_OP, 11=S_DONE), for status LEDs.
- `operands_valid` output 1: high only in S_DONE.

Behaviour:
- Reset (synchronous, `rst`=1 at a clk edge):
  - A=0, B=0, ALU_OP=0, state=S_A, operands_valid=0.
  - Synchronizer/debounce/edge registers are cleared, and the button-level registers reset to 0 (released).
- Reset mid-entry discards all partial operands. A button held through reset produces no pulse until it is released and pressed again.
- Button conditioning, per button:
  - 2-flop synchronizer, then debounce, then rising-edge detector.
  - Output is a 1-cycle pulse (`load_p` / `next_p`).
  - Latency: raw level stable → pulse asserted 2 + DB_CYCLES cycles later (±1).
  - Holding a button yields exactly one pulse.
- Load (`load_p`):
  - In S_A with BYTE_SEL=0..3: A[8*k+7:8*k] ← SW, where k=BYTE_SEL. The other bytes are unchanged.
  - In S_B: same rule, applied to B.
  - In S_A/S_B with BYTE_SEL[2]=1: no write.
  - In S_OP: ALU_OP ← SW[OP_W-1:0]; BYTE_SEL is ignored.
  - In S_DONE: ignored.
  - Registers update on the edge at which the pulse is high, so they are visible the next cycle.
- Next (`next_p`): S_A→S_B→S_OP→S_DONE→S_A.
  - Leaving S_DONE clears operands_valid.
  - A, B and ALU_OP are retained, so the user re-edits only the bytes that change.
- Simultaneous `load_p` and `next_p`: the load is applied to the current state's target, and the state advances on the same edge.
- operands_valid is registered. It rises the cycle after the next_p that enters S_DONE and falls the cycle after the next_p that leaves it.
- No other state transitions exist; entry_state never takes an illegal value.

Optional Feature:
- Macro: `OPERAND_ENTRY_DEBOUNCE_EN`.
- Defined: the full debounce counter is present. A synchronized level must be stable for DB_CYCLES consecutive cycles before the debounced level changes; the counter restarts on any change.
- Undefined: the debounce counter is removed. The pulse is derived directly from the synchronized level, so latency is 2–3 cycles. Used for simulation and for already-debounced board inputs; DB_CYCLES is ignored.

Decomposition:
- Shared package `alu_io_pkg`:
  - Entry-state encodings `S_A`, `S_B`, `S_OP`, `S_DONE`.
  - Byte-lane select constants `LANE0`..`LANE3`.
  - `OP_W`.
  - The display uses the same lane constants.
- Sub-module `btn_pulse`:
  - Ports: clk, rst, raw in, pulse out.
  - Contains the synchronizer, the optional debounce and the edge detect.
  - Instantiated twice.

Test Plan (macro undefined unless stated):
- Reset, then load SW=78/56/34/12 with BYTE_SEL=0/1/2/3 in S_A → A=32'h12345678, B=0, entry_state=00, operands_valid=0.
- next; load SW=FF with BYTE_SEL=1; then load SW=AA with BYTE_SEL=5 → B=32'h0000FF00; A is unchanged at 32'h12345678.
- next; load SW=8'b1111_0101 with any BYTE_SEL; next → ALU_OP=3'b101, entry_state=11, operands_valid=1; a further load in S_DONE changes nothing.
- next from S_DONE → entry_state=00, operands_valid=0, A/B/ALU_OP retained; then load and next pulses on the same edge with SW=0x11, BYTE_SEL=0 → A=32'h12345611 and state=S_B.
- Assert rst while in S_OP with a button held → all outputs return to reset values, and no load occurs until the button is released and re-pressed.
- Macro defined, DB_CYCLES=8: BTN_LOAD bouncing 1-0-1-1-0 (1-cycle glitches) then held high for 20 cycles → exactly one write, occurring 10–11 cycles after the final rising edge.
